// File: rtl/shared_buffer_vc_queue_manager_if.sv
// Handshake bundle between the VC queue manager, its ingress/egress ports and the free-list tracker.
interface shared_buffer_vc_queue_manager_if #(
  parameter int memory_bank_depth = 32,
  parameter int num_vcs = 4
);
  localparam int addr_w = $clog2(memory_bank_depth);
  localparam int vc_w = (num_vcs > 1) ? $clog2(num_vcs) : 1;

  logic              wr_valid;
  logic [vc_w-1:0]   wr_vc;
  logic              wr_ready;
  logic [addr_w-1:0] mem_wr_addr;
  logic              rd_valid;
  logic [vc_w-1:0]   rd_vc;
  logic              rd_ready;
  logic [addr_w-1:0] mem_rd_addr;
  logic [addr_w-1:0] alloc_slot;
  logic              free_list_empty;
  logic              alloc_req;
  logic              release_valid;
  logic [addr_w-1:0] release_slot;
  logic [num_vcs-1:0] vc_empty;
  logic [num_vcs-1:0] vc_full;

  modport master (
    output wr_valid, wr_vc, rd_valid, rd_vc, alloc_slot, free_list_empty,
    input  wr_ready, mem_wr_addr, rd_ready, mem_rd_addr, alloc_req,
           release_valid, release_slot, vc_empty, vc_full
  );

  modport slave (
    input  wr_valid, wr_vc, rd_valid, rd_vc, alloc_slot, free_list_empty,
    output wr_ready, mem_wr_addr, rd_ready, mem_rd_addr, alloc_req,
           release_valid, release_slot, vc_empty, vc_full
  );
endinterface

// File: rtl/shared_buffer_vc_queue_manager.sv
// Linked-list virtual-channel queues over a shared buffer bank, fed by an external free-list tracker.
//
// state  | meaning
// READY  | tracker alloc_slot is valid, a write may be accepted
// SETTLE | tracker is popping, alloc_slot not yet updated
module shared_buffer_vc_queue_manager #(
  parameter int memory_bank_depth = 32,
  parameter int num_vcs = 4,
  parameter int max_vc_slots = 16
) (
  input logic clk,
  input logic reset,
  shared_buffer_vc_queue_manager_if.slave bus
);
  localparam int addr_w = $clog2(memory_bank_depth);
  localparam int vc_w = (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int cnt_w = $clog2(max_vc_slots + 1);

  typedef enum logic {READY, SETTLE} state_t;
  state_t state_q, state_nxt;

  logic [addr_w-1:0]  head [num_vcs];
  logic [addr_w-1:0]  tail [num_vcs];
  logic [cnt_w-1:0]   count [num_vcs];
  logic [cnt_w-1:0]   count_nxt [num_vcs];
  logic [addr_w-1:0]  next_ptr [memory_bank_depth];
  logic [num_vcs-1:0] vc_empty_q, vc_full_q, wr_hit, rd_hit;
  logic               wr_go, rd_go, link_en;

  always_comb begin
    wr_go = reset && bus.wr_valid && (state_q == READY) && !bus.free_list_empty
            && !vc_full_q[bus.wr_vc];
    rd_go = reset && bus.rd_valid && !vc_empty_q[bus.rd_vc];
    state_nxt = READY;
    if (state_q == READY && wr_go) state_nxt = SETTLE;
    for (int v = 0; v < num_vcs; v++) begin
      wr_hit[v] = wr_go && (bus.wr_vc == vc_w'(v));
      rd_hit[v] = rd_go && (bus.rd_vc == vc_w'(v));
      count_nxt[v] = count[v] + cnt_w'(wr_hit[v]) - cnt_w'(rd_hit[v]);
    end
    // Linking is skipped when the write lands on an empty list or replaces its only entry;
    // the old tail slot may already belong to another VC.
    link_en = wr_go && (count[bus.wr_vc] != '0)
              && !(rd_go && (bus.rd_vc == bus.wr_vc) && (count[bus.wr_vc] == cnt_w'(1)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= READY;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < num_vcs; v++) begin
        head[v]  <= '0;
        tail[v]  <= '0;
        count[v] <= '0;
      end
      for (int s = 0; s < memory_bank_depth; s++) next_ptr[s] <= '0;
      vc_empty_q <= '1;
      vc_full_q  <= '0;
    end else begin
      if (link_en) next_ptr[tail[bus.wr_vc]] <= bus.alloc_slot;
      for (int v = 0; v < num_vcs; v++) begin
        if (rd_hit[v]) head[v] <= next_ptr[head[v]];
        if (wr_hit[v]) begin
          tail[v] <= bus.alloc_slot;
          if ((count[v] == '0) || (rd_hit[v] && count[v] == cnt_w'(1)))
            head[v] <= bus.alloc_slot;
        end
        count[v]      <= count_nxt[v];
        vc_empty_q[v] <= (count_nxt[v] == '0);
        vc_full_q[v]  <= (count_nxt[v] == cnt_w'(max_vc_slots));
      end
    end
  end

  assign bus.wr_ready      = wr_go;
  assign bus.alloc_req     = wr_go;
  assign bus.mem_wr_addr   = bus.alloc_slot;
  assign bus.rd_ready      = rd_go;
  assign bus.release_valid = rd_go;
  assign bus.mem_rd_addr   = head[bus.rd_vc];
  assign bus.release_slot  = head[bus.rd_vc];
  assign bus.vc_empty      = vc_empty_q;
  assign bus.vc_full       = vc_full_q;
endmodule

// File: tb/tb_shared_buffer_vc_queue_manager.sv
// Directed bench for the shared-buffer VC queue manager with hand-computed expectations.
module tb_shared_buffer_vc_queue_manager;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0;
  int n_miss = 0;

  shared_buffer_vc_queue_manager_if #(.memory_bank_depth(32), .num_vcs(4)) bus ();

  shared_buffer_vc_queue_manager #(
    .memory_bank_depth(32), .num_vcs(4), .max_vc_slots(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] vc, input logic [4:0] slot);
    bus.wr_valid = 1'b1; bus.wr_vc = vc; bus.alloc_slot = slot;
    #1 chk("wr_accept", bus.wr_ready, 1'b1);
    step();
    bus.wr_valid = 1'b0;
    step();
  endtask

  task automatic rd(input logic [1:0] vc, input logic [4:0] exp_slot);
    bus.rd_valid = 1'b1; bus.rd_vc = vc;
    #1 chk("rd_accept", bus.rd_ready, 1'b1);
    chk("rd_release", bus.release_slot, exp_slot);
    step();
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 1'b1; bus.wr_vc = '0; bus.rd_valid = 1'b1; bus.rd_vc = '0;
    bus.alloc_slot = '0; bus.free_list_empty = 1'b0;
    step(); step();
    chk("rst_vc_empty", bus.vc_empty, 4'hf);
    chk("rst_vc_full", bus.vc_full, 4'h0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_alloc_req", bus.alloc_req, 1'b0);
    chk("rst_rd_ready", bus.rd_ready, 1'b0);
    chk("rst_release", bus.release_valid, 1'b0);
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    reset = 1'b1;
    step();

    // back-to-back writes: second is refused during SETTLE
    bus.wr_valid = 1'b1; bus.wr_vc = 2'd0; bus.alloc_slot = 5'd0;
    #1 chk("b2b_wr_ready_n", bus.wr_ready, 1'b1);
    chk("b2b_alloc_req_n", bus.alloc_req, 1'b1);
    chk("mem_wr_addr", bus.mem_wr_addr, 5'd0);
    step();
    bus.alloc_slot = 5'd1;
    #1 chk("b2b_wr_ready_n1", bus.wr_ready, 1'b0);
    chk("b2b_alloc_req_n1", bus.alloc_req, 1'b0);
    chk("vc_empty_after_wr", bus.vc_empty, 4'he);
    step();
    #1 chk("wr2_ready", bus.wr_ready, 1'b1);
    step();
    bus.wr_valid = 1'b0;
    step();
    chk("vc_empty_two", bus.vc_empty, 4'he);

    // drain VC0 in order 0 then 1
    bus.rd_valid = 1'b1; bus.rd_vc = 2'd0;
    #1 chk("rd0_mem_rd_addr", bus.mem_rd_addr, 5'd0);
    chk("rd0_release_valid", bus.release_valid, 1'b1);
    chk("rd0_release_slot", bus.release_slot, 5'd0);
    step();
    chk("rd1_release_slot", bus.release_slot, 5'd1);
    chk("rd1_mem_rd_addr", bus.mem_rd_addr, 5'd1);
    chk("rd1_vc_empty_pre", bus.vc_empty, 4'he);
    step();
    chk("vc0_empty_after", bus.vc_empty, 4'hf);
    chk("rd_empty_reject", bus.rd_ready, 1'b0);
    chk("rd_empty_no_rel", bus.release_valid, 1'b0);
    bus.rd_valid = 1'b0;

    // single-entry VC1: simultaneous read and write replace the entry
    wr(2'd1, 5'd5);
    chk("vc1_one", bus.vc_empty, 4'hd);
    bus.rd_valid = 1'b1; bus.rd_vc = 2'd1;
    bus.wr_valid = 1'b1; bus.wr_vc = 2'd1; bus.alloc_slot = 5'd7;
    #1 chk("rw1_release_slot", bus.release_slot, 5'd5);
    chk("rw1_wr_ready", bus.wr_ready, 1'b1);
    chk("rw1_rd_ready", bus.rd_ready, 1'b1);
    step();
    bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
    chk("rw1_count_one", bus.vc_empty, 4'hd);
    step();
    rd(2'd1, 5'd7);
    chk("vc1_drained", bus.vc_empty, 4'hf);

    // multi-entry VC1: simultaneous read/write keeps list order
    wr(2'd1, 5'd10);
    wr(2'd1, 5'd11);
    bus.rd_valid = 1'b1; bus.rd_vc = 2'd1;
    bus.wr_valid = 1'b1; bus.wr_vc = 2'd1; bus.alloc_slot = 5'd12;
    #1 chk("rw2_release_slot", bus.release_slot, 5'd10);
    step();
    bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
    step();
    rd(2'd1, 5'd11);
    chk("rw2_not_empty", bus.vc_empty, 4'hd);
    rd(2'd1, 5'd12);
    chk("rw2_empty", bus.vc_empty, 4'hf);

    // write and read on different VCs in the same cycle
    wr(2'd0, 5'd3);
    bus.rd_valid = 1'b1; bus.rd_vc = 2'd0;
    bus.wr_valid = 1'b1; bus.wr_vc = 2'd3; bus.alloc_slot = 5'd4;
    #1 chk("diff_release", bus.release_slot, 5'd3);
    chk("diff_wr_ready", bus.wr_ready, 1'b1);
    step();
    bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
    chk("diff_vc_empty", bus.vc_empty, 4'h7);
    step();
    rd(2'd3, 5'd4);

    // fill VC2 to its cap
    for (int i = 0; i < 16; i++) begin
      wr(2'd2, 5'(16 + i));
      if (i == 14) chk("vc2_not_full", bus.vc_full, 4'h0);
    end
    chk("vc2_full", bus.vc_full, 4'h4);
    chk("vc2_nonempty", bus.vc_empty, 4'hb);
    bus.wr_valid = 1'b1; bus.wr_vc = 2'd2;
    #1 chk("full_wr_ready", bus.wr_ready, 1'b0);
    chk("full_alloc_req", bus.alloc_req, 1'b0);
    bus.wr_vc = 2'd3;
    #1 chk("other_vc_ready", bus.wr_ready, 1'b1);
    bus.free_list_empty = 1'b1;
    for (int v = 0; v < 4; v++) begin
      bus.wr_vc = 2'(v);
      #1 chk("fl_empty_block", bus.wr_ready, 1'b0);
    end
    bus.wr_valid = 1'b0; bus.free_list_empty = 1'b0;
    step();

    // reset mid-operation with VC3 holding three flits
    wr(2'd3, 5'd1);
    wr(2'd3, 5'd2);
    wr(2'd3, 5'd3);
    bus.rd_valid = 1'b1; bus.rd_vc = 2'd3;
    bus.wr_valid = 1'b1; bus.wr_vc = 2'd0;
    #1 chk("pre_rst_release", bus.release_valid, 1'b1);
    chk("pre_rst_slot", bus.release_slot, 5'd1);
    #1 reset = 1'b0;
    #1 chk("mid_rst_release", bus.release_valid, 1'b0);
    chk("mid_rst_rd_ready", bus.rd_ready, 1'b0);
    chk("mid_rst_wr_ready", bus.wr_ready, 1'b0);
    chk("mid_rst_alloc_req", bus.alloc_req, 1'b0);
    chk("mid_rst_vc_empty", bus.vc_empty, 4'hf);
    chk("mid_rst_vc_full", bus.vc_full, 4'h0);
    step();
    chk("hold_rst_release", bus.release_valid, 1'b0);
    bus.wr_valid = 1'b0;
    reset = 1'b1;
    #1 chk("post_rst_rd_reject", bus.rd_ready, 1'b0);
    bus.rd_valid = 1'b0;
    step();
    wr(2'd3, 5'd9);
    chk("post_rst_vc_empty", bus.vc_empty, 4'h7);
    rd(2'd3, 5'd9);
    chk("post_rst_drained", bus.vc_empty, 4'hf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
